// File: rtl/wb_stage_if.sv
// Interface bundling the memory-stage handshake, data-memory response,
// register-file write port and forwarding outputs of the writeback stage.
interface wb_stage_if #(parameter int XLEN = 32);
   logic            in_valid;
   logic            in_ready;
   logic [4:0]      in_rd;
   logic            in_regwr;
   logic [1:0]      in_wbsel;
   logic [2:0]      in_funct3;
   logic [1:0]      in_addrlo;
   logic [XLEN-1:0] in_alu;
   logic [XLEN-1:0] in_pc;
   logic            dmem_rvalid;
   logic [XLEN-1:0] dmem_rdata;
   logic [4:0]      rdaddr;
   logic [XLEN-1:0] win;
   logic            regwr;
   logic            busy;
   logic            misalign_err;
   logic            fwd_valid;
   logic [4:0]      fwd_rd;
   logic [XLEN-1:0] fwd_data;

   modport master (
      output in_valid, in_rd, in_regwr, in_wbsel, in_funct3, in_addrlo,
             in_alu, in_pc, dmem_rvalid, dmem_rdata,
      input  in_ready, rdaddr, win, regwr, busy, misalign_err,
             fwd_valid, fwd_rd, fwd_data
   );

   modport slave (
      input  in_valid, in_rd, in_regwr, in_wbsel, in_funct3, in_addrlo,
             in_alu, in_pc, dmem_rvalid, dmem_rdata,
      output in_ready, rdaddr, win, regwr, busy, misalign_err,
             fwd_valid, fwd_rd, fwd_data
   );
endinterface

// File: rtl/wb_stage.sv
// r200 writeback stage: result select, load wait/align/extend, single-cycle regfile write.
// Optional macro WB_FWD_EN builds registered forwarding copies of regwr/rdaddr/win.
//
// state       | meaning
// S_IDLE      | no instruction in flight, ready to accept
// S_WAIT_LOAD | load accepted, waiting for dmem_rvalid; not ready
// S_COMMIT    | write (or error) presented this cycle, ready to accept
module wb_stage #(
   parameter int XLEN = 32
) (
   input logic       clk,
   input logic       rst,
   wb_stage_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_LOAD = 2'd1,
      S_COMMIT    = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [4:0]      rdaddr_d;
   logic [XLEN-1:0] win_d;
   logic            regwr_d, merr_d, busy_d;
   logic [4:0]      ld_rd_q, ld_rd_d;
   logic            ld_regwr_q, ld_regwr_d;
   logic [2:0]      ld_funct3_q, ld_funct3_d;
   logic [1:0]      ld_addrlo_q, ld_addrlo_d;
   logic            accept, ld_ok;
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [XLEN-1:0] ld_data;

   assign bus.in_ready = (state_q != S_WAIT_LOAD);
   assign accept       = bus.in_valid && bus.in_ready;

   // legal load types and their natural alignment
   always_comb begin
      ld_ok = 1'b0;
      case (bus.in_funct3)
         3'b000, 3'b100: ld_ok = 1'b1;
         3'b001, 3'b101: ld_ok = ~bus.in_addrlo[0];
         3'b010:         ld_ok = (bus.in_addrlo == 2'b00);
         default:        ld_ok = 1'b0;
      endcase
   end

   assign ld_byte = bus.dmem_rdata[{ld_addrlo_q, 3'b000} +: 8];
   assign ld_half = ld_addrlo_q[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];

   always_comb begin
      ld_data = bus.dmem_rdata;
      case (ld_funct3_q)
         3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
         3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
         3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
         default: ld_data = bus.dmem_rdata;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      rdaddr_d    = bus.rdaddr;
      win_d       = bus.win;
      regwr_d     = 1'b0;
      merr_d      = 1'b0;
      ld_rd_d     = ld_rd_q;
      ld_regwr_d  = ld_regwr_q;
      ld_funct3_d = ld_funct3_q;
      ld_addrlo_d = ld_addrlo_q;

      case (state_q)
         S_WAIT_LOAD: begin
            if (bus.dmem_rvalid) begin
               state_d  = S_COMMIT;
               rdaddr_d = ld_rd_q;
               win_d    = ld_data;
               regwr_d  = ld_regwr_q && (ld_rd_q != 5'd0);
            end
         end
         default: begin
            if (!accept) begin
               state_d = S_IDLE;
            end else if (bus.in_wbsel == 2'b01) begin
               if (ld_ok) begin
                  state_d     = S_WAIT_LOAD;
                  ld_rd_d     = bus.in_rd;
                  ld_regwr_d  = bus.in_regwr;
                  ld_funct3_d = bus.in_funct3;
                  ld_addrlo_d = bus.in_addrlo;
               end else begin
                  // bad load retires immediately with no write
                  state_d = S_COMMIT;
                  merr_d  = 1'b1;
               end
            end else begin
               state_d  = S_COMMIT;
               rdaddr_d = bus.in_rd;
               regwr_d  = bus.in_regwr && (bus.in_rd != 5'd0);
               case (bus.in_wbsel)
                  2'b00:   win_d = bus.in_alu;
                  2'b10:   win_d = bus.in_pc + XLEN'(4);
                  default: win_d = '0;
               endcase
            end
         end
      endcase

      busy_d = (state_d == S_WAIT_LOAD);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= S_IDLE;
         bus.rdaddr       <= 5'd0;
         bus.win          <= '0;
         bus.regwr        <= 1'b0;
         bus.misalign_err <= 1'b0;
         bus.busy         <= 1'b0;
         ld_rd_q          <= 5'd0;
         ld_regwr_q       <= 1'b0;
         ld_funct3_q      <= 3'd0;
         ld_addrlo_q      <= 2'd0;
      end else begin
         state_q          <= state_d;
         bus.rdaddr       <= rdaddr_d;
         bus.win          <= win_d;
         bus.regwr        <= regwr_d;
         bus.misalign_err <= merr_d;
         bus.busy         <= busy_d;
         ld_rd_q          <= ld_rd_d;
         ld_regwr_q       <= ld_regwr_d;
         ld_funct3_q      <= ld_funct3_d;
         ld_addrlo_q      <= ld_addrlo_d;
      end
   end

`ifdef WB_FWD_EN
   // loaded from the same next-values so they match regwr/rdaddr/win every cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.fwd_valid <= 1'b0;
         bus.fwd_rd    <= 5'd0;
         bus.fwd_data  <= '0;
      end else begin
         bus.fwd_valid <= regwr_d;
         bus.fwd_rd    <= rdaddr_d;
         bus.fwd_data  <= win_d;
      end
   end
`else
   assign bus.fwd_valid = 1'b0;
   assign bus.fwd_rd    = 5'd0;
   assign bus.fwd_data  = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_wb_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;

   wb_stage_if #(.XLEN(32)) bus ();

   wb_stage #(.XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // reference model: architectural view of outputs plus one pending load
   logic        m_pending;
   logic [4:0]  m_ld_rd;
   logic        m_ld_regwr;
   logic [2:0]  m_ld_f3;
   logic [1:0]  m_ld_lo;
   logic [4:0]  m_rdaddr;
   logic [31:0] m_win;
   logic        m_regwr;
   logic        m_merr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pending  = 1'b0;
      m_ld_rd    = 5'd0;
      m_ld_regwr = 1'b0;
      m_ld_f3    = 3'd0;
      m_ld_lo    = 2'd0;
      m_rdaddr   = 5'd0;
      m_win      = 32'd0;
      m_regwr    = 1'b0;
      m_merr     = 1'b0;
   endtask

   function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] word);
      logic [31:0] b, h;
      b = (word >> (8 * lo)) & 32'hFF;
      h = (word >> (16 * (lo / 2))) & 32'hFFFF;
      case (f3)
         3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
         3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
         3'b100:  return b;
         3'b101:  return h;
         default: return word;
      endcase
   endfunction

   // advance the model by one clock given the inputs currently driven
   task automatic model_step();
      logic nregwr, nmerr, legal;
      int   size;
      nregwr = 1'b0;
      nmerr  = 1'b0;
      if (m_pending) begin
         if (bus.dmem_rvalid) begin
            m_rdaddr  = m_ld_rd;
            m_win     = load_value(m_ld_f3, m_ld_lo, bus.dmem_rdata);
            nregwr    = m_ld_regwr && (m_ld_rd != 0);
            m_pending = 1'b0;
         end
      end else if (bus.in_valid) begin
         if (bus.in_wbsel == 2'b01) begin
            legal = (bus.in_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
            size  = (bus.in_funct3[1:0] == 2'b00) ? 1 : (bus.in_funct3[1:0] == 2'b01) ? 2 : 4;
            if (legal && (int'(bus.in_addrlo) % size == 0)) begin
               m_pending  = 1'b1;
               m_ld_rd    = bus.in_rd;
               m_ld_regwr = bus.in_regwr;
               m_ld_f3    = bus.in_funct3;
               m_ld_lo    = bus.in_addrlo;
            end else begin
               nmerr = 1'b1;
            end
         end else begin
            m_rdaddr = bus.in_rd;
            m_win    = (bus.in_wbsel == 2'b00) ? bus.in_alu :
                       (bus.in_wbsel == 2'b10) ? bus.in_pc + 32'd4 : 32'd0;
            nregwr   = bus.in_regwr && (bus.in_rd != 0);
         end
      end
      m_regwr = nregwr;
      m_merr  = nmerr;
   endtask

   task automatic check_all(input string ctx);
      chk({ctx, ".in_ready"}, 32'(bus.in_ready), 32'(!m_pending));
      chk({ctx, ".busy"}, 32'(bus.busy), 32'(m_pending));
      chk({ctx, ".regwr"}, 32'(bus.regwr), 32'(m_regwr));
      chk({ctx, ".misalign_err"}, 32'(bus.misalign_err), 32'(m_merr));
      chk({ctx, ".rdaddr"}, 32'(bus.rdaddr), 32'(m_rdaddr));
      chk({ctx, ".win"}, bus.win, m_win);
`ifdef WB_FWD_EN
      chk({ctx, ".fwd_valid"}, 32'(bus.fwd_valid), 32'(m_regwr));
      chk({ctx, ".fwd_rd"}, 32'(bus.fwd_rd), 32'(m_rdaddr));
      chk({ctx, ".fwd_data"}, bus.fwd_data, m_win);
`else
      chk({ctx, ".fwd_valid"}, 32'(bus.fwd_valid), 32'd0);
      chk({ctx, ".fwd_rd"}, 32'(bus.fwd_rd), 32'd0);
      chk({ctx, ".fwd_data"}, bus.fwd_data, 32'd0);
`endif
   endtask

   task automatic drive(input logic v, input logic [4:0] rd, input logic rw,
                        input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] lo,
                        input logic [31:0] alu, input logic [31:0] pc,
                        input logic rv, input logic [31:0] rdata);
      bus.in_valid    = v;
      bus.in_rd       = rd;
      bus.in_regwr    = rw;
      bus.in_wbsel    = sel;
      bus.in_funct3   = f3;
      bus.in_addrlo   = lo;
      bus.in_alu      = alu;
      bus.in_pc       = pc;
      bus.dmem_rvalid = rv;
      bus.dmem_rdata  = rdata;
   endtask

   task automatic idle_in();
      drive(1'b0, 5'd0, 1'b0, 2'b00, 3'd0, 2'd0, 32'd0, 32'd0, 1'b0, 32'd0);
   endtask

   // called at negedge with inputs driven; returns at next negedge after checking
   task automatic tick(input string ctx);
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_all(ctx);
   endtask

   initial begin
      model_reset();
      idle_in();
      repeat (2) @(negedge clk);
      check_all("reset");
      rst = 1'b0;

      // ALU writeback
      drive(1'b1, 5'd5, 1'b1, 2'b00, 3'd0, 2'd0, 32'hDEADBEEF, 32'h100, 1'b0, 32'd0);
      tick("alu");
      chk("alu_win_const", bus.win, 32'hDEADBEEF);
      chk("alu_regwr_const", 32'(bus.regwr), 32'd1);
      idle_in();
      tick("alu_idle");
      chk("alu_idle_regwr", 32'(bus.regwr), 32'd0);

      // LB then LBU, response after 3 wait cycles
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, 5'd7, 1'b1, 2'b01, (k == 0) ? 3'b000 : 3'b100, 2'd2, 32'd0, 32'd0, 1'b0, 32'd0);
         tick("ld_acc");
         idle_in();
         for (int c = 0; c < 3; c++) begin
            chk("ld_wait_busy", 32'(bus.busy), 32'd1);
            chk("ld_wait_ready", 32'(bus.in_ready), 32'd0);
            if (c < 2) tick("ld_wait");
         end
         bus.dmem_rvalid = 1'b1;
         bus.dmem_rdata  = 32'h12F45678;
         tick("ld_resp");
         chk("ld_win_const", bus.win, (k == 0) ? 32'hFFFFFFF4 : 32'h000000F4);
         chk("ld_regwr_const", 32'(bus.regwr), 32'd1);
         idle_in();
         tick("ld_idle");
      end

      // misaligned LW, then a stray response
      drive(1'b1, 5'd9, 1'b1, 2'b01, 3'b010, 2'd1, 32'd0, 32'd0, 1'b0, 32'd0);
      tick("mis");
      chk("mis_err_const", 32'(bus.misalign_err), 32'd1);
      chk("mis_regwr_const", 32'(bus.regwr), 32'd0);
      chk("mis_busy_const", 32'(bus.busy), 32'd0);
      drive(1'b0, 5'd0, 1'b0, 2'b00, 3'd0, 2'd0, 32'd0, 32'd0, 1'b1, 32'hCAFEF00D);
      tick("mis_stale");
      chk("mis_stale_regwr", 32'(bus.regwr), 32'd0);
      idle_in();
      tick("mis_idle");

      // back-to-back JAL with PC wrap then rd=x0
      drive(1'b1, 5'd1, 1'b1, 2'b10, 3'd0, 2'd0, 32'h0, 32'hFFFFFFFC, 1'b0, 32'd0);
      tick("jal");
      chk("jal_win_const", bus.win, 32'h00000000);
      chk("jal_regwr_const", 32'(bus.regwr), 32'd1);
      drive(1'b1, 5'd0, 1'b1, 2'b00, 3'd0, 2'd0, 32'h1234, 32'h0, 1'b0, 32'd0);
      tick("x0");
      chk("x0_regwr_const", 32'(bus.regwr), 32'd0);
      idle_in();
      tick("x0_idle");

      // reset while a load is pending
      drive(1'b1, 5'd3, 1'b1, 2'b01, 3'b001, 2'd2, 32'd0, 32'd0, 1'b0, 32'd0);
      tick("rst_acc");
      idle_in();
      tick("rst_wait");
      rst = 1'b1;
      #1;
      model_reset();
      check_all("rst_async");
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 5'd0, 1'b0, 2'b00, 3'd0, 2'd0, 32'd0, 32'd0, 1'b1, 32'h8000FFFF);
      tick("rst_stale");
      chk("rst_stale_regwr", 32'(bus.regwr), 32'd0);
      chk("rst_stale_ready", 32'(bus.in_ready), 32'd1);
      idle_in();
      tick("rst_idle");

      // random traffic, including stale responses and illegal loads
      for (int i = 0; i < 600; i++) begin
         logic [4:0] rd;
         rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
         drive(($urandom_range(0, 3) != 0), rd, 1'($urandom), 2'($urandom),
               3'($urandom), 2'($urandom), $urandom, $urandom,
               ($urandom_range(0, 2) == 0), $urandom);
         if ($urandom_range(0, 1) == 0) bus.in_wbsel = 2'b01;
         tick("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
